// File: rtl/nibble_serial_add_seq.sv
// Serialises one WIDTH-bit add onto an external 4-bit adder, LSB nibble first,
// collects the result and counts results that differ from the exact sum.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             mismatch,
  input  logic             err_clr,
  output logic [ERRW-1:0]  err_count
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [ERRW-1:0]  err_q, err_d;

  logic             is_idle, is_run, is_done;
  logic [WIDTH:0]   exact;
  logic             fire;

  assign is_idle = (state_q == S_IDLE);
  assign is_run  = (state_q == S_RUN);
  assign is_done = (state_q == S_DONE);

  // Exact reference over the latched operands, one bit wider for the carry.
  assign exact = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

  assign in_ready  = is_idle;
  assign out_valid = is_done;
  assign out_sum   = is_done ? sum_q : '0;
  assign out_cout  = is_done & carry_q;
  assign mismatch  = is_done && (exact != {carry_q, sum_q});
  assign err_count = err_q;
  assign fire      = is_done & out_ready;

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (is_run) begin
      add_a   = a_q[4*idx_q +: 4];
      add_b   = b_q[4*idx_q +: 4];
      add_cin = carry_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = add_s;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-edge increment; the counter saturates.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (fire && mismatch && (err_q != {ERRW{1'b1}})) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed and random checks of the nibble-serial add sequencer against
// exact, bit-flipping and approximate 4-bit adder models.
module tb_nibble_serial_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [15:0] in_a, in_b;
  logic        in_cin;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic [3:0]  add_a2, add_b2, add_s2;
  logic        add_cin2, add_cout2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [15:0] out_sum, out_sum2;
  logic        out_cout, out_cout2;
  logic        mismatch, mismatch2;
  logic        err_clr;
  logic [7:0]  err_count;
  logic [1:0]  err_count2;

  int mode;
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: exact, 1: exact with sum bit 0 inverted, 2: approximate
  function automatic logic [4:0] mdl(input int m, input logic [3:0] a,
                                     input logic [3:0] b, input logic c);
    logic [4:0] t;
    logic [3:0] lo;
    t = {1'b0, a} + {1'b0, b} + {4'd0, c};
    if (m == 1) begin
      t[0] = ~t[0];
    end else if (m == 2) begin
      lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'd0, c};
      t = {a[3] & b[3], a[3] ^ b[3], lo[2:0]};
    end
    return t;
  endfunction

  always_comb {add_cout, add_s} = mdl(mode, add_a, add_b, add_cin);
  always_comb {add_cout2, add_s2} = mdl(mode, add_a2, add_b2, add_cin2);

  nibble_serial_add_seq #(.WIDTH(16), .ERRW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .mismatch(mismatch), .err_clr(err_clr),
    .err_count(err_count)
  );

  nibble_serial_add_seq #(.WIDTH(16), .ERRW(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
    .add_s(add_s2), .add_cout(add_cout2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_cout(out_cout2),
    .mismatch(mismatch2), .err_clr(err_clr),
    .err_count(err_count2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE; lat counts edges from the accept edge on.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic clr,
                     output logic [15:0] s, output logic co,
                     output logic mis, output int lat);
    in_a = a;
    in_b = b;
    in_cin = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = out_sum;
    co = out_cout;
    mis = mismatch;
    out_ready = 1'b1;
    err_clr = clr;
    tick();
    out_ready = 1'b0;
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] s;
    logic co, mis;
    int lat;
    int tally;
    logic [15:0] ra, rb, gs;
    logic rc, gc;
    logic [4:0] nr;
    logic [16:0] ex;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    total = 0;
    bad = 0;
    mode = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_cin = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    chk("rst_out", {out_sum, out_cout, mismatch}, 0);
    chk("rst_err", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, mis, lat);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].cout);
      chk($sformatf("vec%0d_mis", i), mis, 0);
      chk($sformatf("vec%0d_lat", i), lat, 5);
    end
    chk("exact_err", err_count, 0);

    // Result held while out_ready is low; a new request is ignored.
    in_a = 16'h1234;
    in_b = 16'h0FFF;
    in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("hold_valid0", out_valid, 1);
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_valid%0d", i + 1), out_valid, 1);
      chk($sformatf("hold_sum%0d", i + 1), out_sum, 16'h2233);
      chk($sformatf("hold_ready%0d", i + 1), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid", out_valid, 0);
    chk("hs_ready", in_ready, 1);
    run(16'h0F0F, 16'h00F1, 1'b0, 1'b0, s, co, mis, lat);
    chk("after_hold_sum", {co, s}, 17'h01000);

    // Every result wrong: counters step and the 2-bit one saturates.
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      run(16'h1111 * i, 16'h0203, 1'b0, 1'b0, s, co, mis, lat);
      chk($sformatf("flip%0d_mis", i), mis, 1);
      chk($sformatf("flip%0d_err", i), err_count, i + 1);
      chk($sformatf("flip%0d_err2", i), err_count2, (i < 3) ? i + 1 : 3);
    end

    // Reset in RUN at idx 2 aborts and clears the counters.
    mode = 0;
    in_a = 16'hABCD;
    in_b = 16'h1357;
    in_cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_add_a", add_a, 4'hB);
    chk("mid_add_b", add_b, 4'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_add", {add_a, add_b, add_cin}, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_err2", err_count2, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run(16'hABCD, 16'h1357, 1'b1, 1'b0, s, co, mis, lat);
    chk("post_rst_sum", {co, s}, 17'h0BF25);
    chk("post_rst_mis", mis, 0);

    // Clear wins over a concurrent mismatched handshake.
    mode = 1;
    run(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, mis, lat);
    chk("pre_clr_err", err_count, 1);
    run(16'h0002, 16'h0003, 1'b0, 1'b1, s, co, mis, lat);
    chk("clr_mis", mis, 1);
    chk("clr_err", err_count, 0);
    chk("clr_err2", err_count2, 0);

    // Approximate slice against a nibble-chained golden model.
    mode = 2;
    tally = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      gc = rc;
      for (int n = 0; n < 4; n++) begin
        nr = mdl(2, ra[4*n +: 4], rb[4*n +: 4], gc);
        gs[4*n +: 4] = nr[3:0];
        gc = nr[4];
      end
      ex = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      if ({gc, gs} != ex) tally++;
      run(ra, rb, rc, 1'b0, s, co, mis, lat);
      chk($sformatf("apx%0d_res", i), {co, s}, {gc, gs});
      chk($sformatf("apx%0d_mis", i), mis, ({gc, gs} != ex));
    end
    chk("apx_err", err_count, (tally > 255) ? 255 : tally);
    chk("apx_err2", err_count2, (tally > 3) ? 3 : tally);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
